// File: rtl/flash_boot_loader_if.sv
// SPI flash pins and instruction-memory write port driven by the boot loader.
// The loader connects through the master modport; flash and IMEM sides use slave.
interface flash_boot_loader_if #(
    parameter int ADDR_W = 7
);
    logic              o_flash_sclk;
    logic              o_flash_cs_n;
    logic              o_flash_mosi;
    logic              i_flash_miso;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output o_flash_sclk,
        output o_flash_cs_n,
        output o_flash_mosi,
        input  i_flash_miso,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        input  o_flash_sclk,
        input  o_flash_cs_n,
        input  o_flash_mosi,
        output i_flash_miso,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/flash_boot_loader.sv
// Boot sequencer: one SPI READ from flash, streams IMEM_DEPTH little-endian words
// into instruction memory, then releases the core from reset.
module flash_boot_loader #(
    parameter logic [23:0] FLASH_BASE = 24'h100000,
    parameter int          IMEM_DEPTH = 128,
    parameter int          CLK_DIV    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                boot_en,
    flash_boot_loader_if.master bus,
    output logic                core_hold,
    output logic                boot_done
);
    localparam int ADDR_W = $clog2(IMEM_DEPTH);
    localparam int CNT_W  = $clog2(2 * CLK_DIV);

    localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [31:0]       CMD_WORD  = {8'h03, FLASH_BASE};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_WRITE,
        S_CSWAIT,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [4:0]        bit_reg, bit_next;
    logic [31:0]       cmd_reg, cmd_next;
    logic [31:0]       shift_reg, shift_next;
    logic              sclk_reg, sclk_next;
    logic              cs_n_reg, cs_n_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic              done_reg, done_next;
    logic [31:0]       swapped;

    // Bytes arrive B0 first into the MSB end; the IMEM word is {B3,B2,B1,B0}.
    for (genvar gi = 0; gi < 4; gi++) begin : g_swap
        assign swapped[8*gi +: 8] = shift_reg[8*(3-gi) +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            cmd_reg   <= '0;
            shift_reg <= '0;
            sclk_reg  <= 1'b0;
            cs_n_reg  <= 1'b1;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            cmd_reg   <= cmd_next;
            shift_reg <= shift_next;
            sclk_reg  <= sclk_next;
            cs_n_reg  <= cs_n_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        cmd_next   = cmd_reg;
        shift_next = shift_reg;
        sclk_next  = sclk_reg;
        cs_n_next  = cs_n_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        done_next  = done_reg;

        case (state_reg)
            S_IDLE: begin
                if (boot_en) begin
                    state_next = S_CMD;
                    cs_n_next  = 1'b0;
                    cmd_next   = CMD_WORD;
                    cnt_next   = '0;
                    bit_next   = '0;
                end else begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end
            end

            S_CMD, S_DATA: begin
                if (cnt_reg == DIV_LAST) begin
                    cnt_next  = '0;
                    sclk_next = ~sclk_reg;
                    if (!sclk_reg) begin
                        // Rising edge: the flash has held MISO stable since the last fall.
                        if (state_reg == S_DATA) begin
                            shift_next = {shift_reg[30:0], bus.i_flash_miso};
                        end
                    end else begin
                        bit_next = bit_reg + 5'd1;
                        if (state_reg == S_CMD) begin
                            cmd_next = {cmd_reg[30:0], 1'b0};
                        end
                        if (bit_reg == 5'd31) begin
                            if (state_reg == S_CMD) begin
                                state_next = S_DATA;
                                cmd_next   = '0;
                            end else begin
                                state_next = S_WRITE;
                                we_next    = 1'b1;
                                wdata_next = swapped;
                            end
                        end
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            S_WRITE: begin
                cnt_next = '0;
                if (addr_reg == ADDR_LAST) begin
                    state_next = S_CSWAIT;
                    cs_n_next  = 1'b1;
                end else begin
                    // Continuous read: SCLK simply stalls low for this cycle.
                    addr_next  = addr_reg + ADDR_W'(1);
                    state_next = S_DATA;
                end
            end

            S_CSWAIT: begin
                if (cnt_reg == WAIT_LAST) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            S_DONE: begin
                sclk_next = 1'b0;
                cs_n_next = 1'b1;
            end

            default: state_next = S_IDLE;
        endcase
    end

    assign bus.o_flash_sclk = sclk_reg;
    assign bus.o_flash_cs_n = cs_n_reg;
    assign bus.o_flash_mosi = cmd_reg[31];
    assign bus.imem_we      = we_reg;
    assign bus.imem_addr    = addr_reg;
    assign bus.imem_wdata   = wdata_reg;
    assign core_hold        = ~done_reg;
    assign boot_done        = done_reg;
endmodule
